pc_gen: RTL and testbench

Parametrised program-counter generator for the instruction-fetch stage. Next-generation PC: configurable address width and reset vector, optional 16-bit (compressed) instruction stepping, a trap redirect that takes priority over branches, and a small return-address stack (RAS) that predicts function returns. It drives the fetch address every cycle and accepts redirects from execute/trap logic and call/return hints from pre-decode.

---
 rtl/pc_gen.sv | 98 +++++++++
 tb/tb_pc_gen.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - fetch program counter with trap/jump redirect, compressed stepping and a return-address stack
module pc_gen #(
    parameter int                 ADDR_W     = 32,
    parameter logic [ADDR_W-1:0]  RESET_ADDR = '0,
    parameter bit                 C_EXT      = 1'b1,
    parameter int                 RAS_DEPTH  = 4
) (
    input  logic              i_Clk,
    input  logic              i_reset,
    input  logic              i_trap_flag,
    input  logic [ADDR_W-1:0] i_trap_addr,
    input  logic              i_jump_flag,
    input  logic [ADDR_W-1:0] i_jump_addr,
    input  logic              i_hold,
    input  logic              i_is_compressed,
    input  logic              i_push,
    input  logic              i_pop,
    output logic [ADDR_W-1:0] o_pc,
    output logic              o_misaligned,
    output logic              o_ras_empty,
    output logic              o_ras_full
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [ADDR_W-1:0] JUMP_MASK = C_EXT ? ~ADDR_W'(1) : ~ADDR_W'(3);
    localparam logic [ADDR_W-1:0] TRAP_MASK = ~ADDR_W'(3);

    logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
    // ras_ptr is the next free slot; the top entry sits one below it (circularly)
    logic [PTR_W-1:0]  ras_ptr;
    logic [PTR_W-1:0]  top_idx;
    logic [CNT_W-1:0]  ras_cnt;

    logic [ADDR_W-1:0] step;
    logic [ADDR_W-1:0] seq_pc;
    logic [ADDR_W-1:0] pc_next;
    logic              mis_next;
    logic              predict_en;
    logic              pop_ok;
    logic              wr_en;
    logic [PTR_W-1:0]  wr_idx;

    assign o_ras_empty = (ras_cnt == '0);
    assign o_ras_full  = (ras_cnt == CNT_W'(RAS_DEPTH));

    assign step       = (C_EXT && i_is_compressed) ? ADDR_W'(2) : ADDR_W'(4);
    assign seq_pc     = o_pc + step;
    assign top_idx    = ras_ptr - PTR_W'(1);
    assign predict_en = !i_trap_flag && !i_jump_flag && !i_hold;
    assign pop_ok     = predict_en && i_pop && !o_ras_empty;

    // A push paired with a successful pop reuses the popped slot
    assign wr_en  = predict_en && i_push && !i_reset;
    assign wr_idx = pop_ok ? top_idx : ras_ptr;

    always_comb begin
        pc_next  = o_pc;
        mis_next = 1'b0;
        if (i_trap_flag) begin
            pc_next  = i_trap_addr & TRAP_MASK;
            mis_next = |(i_trap_addr & ~TRAP_MASK);
        end else if (i_jump_flag) begin
            pc_next  = i_jump_addr & JUMP_MASK;
            mis_next = |(i_jump_addr & ~JUMP_MASK);
        end else if (!i_hold) begin
            pc_next = pop_ok ? ras_mem[top_idx] : seq_pc;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_reset) begin
            o_pc         <= RESET_ADDR;
            o_misaligned <= 1'b0;
            ras_ptr      <= '0;
            ras_cnt      <= '0;
        end else begin
            o_pc         <= pc_next;
            o_misaligned <= mis_next;
            if (pop_ok && !i_push) begin
                ras_ptr <= top_idx;
                ras_cnt <= ras_cnt - CNT_W'(1);
            end else if (!pop_ok && wr_en) begin
                ras_ptr <= ras_ptr + PTR_W'(1);
                if (!o_ras_full) begin
                    ras_cnt <= ras_cnt + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge i_Clk) begin
        if (wr_en) begin
            ras_mem[wr_idx] <= seq_pc;
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// tb/tb_pc_gen.sv - directed and randomized checks of pc_gen (C_EXT=1 and C_EXT=0 instances) against a list-based model
module tb_pc_gen;

    localparam logic [31:0] RST = 32'h8000_0000;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        trap_flag = 1'b0;
    logic [31:0] trap_addr = '0;
    logic        jump_flag = 1'b0;
    logic [31:0] jump_addr = '0;
    logic        hold = 1'b0;
    logic        comp = 1'b0;
    logic        push = 1'b0;
    logic        pop = 1'b0;

    logic [31:0] pc_c, pc_n;
    logic        mis_c, mis_n, emp_c, emp_n, full_c, full_n;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pc_gen #(.ADDR_W(32), .RESET_ADDR(RST), .C_EXT(1'b1), .RAS_DEPTH(DEPTH)) dut_c (
        .i_Clk(clk), .i_reset(reset),
        .i_trap_flag(trap_flag), .i_trap_addr(trap_addr),
        .i_jump_flag(jump_flag), .i_jump_addr(jump_addr),
        .i_hold(hold), .i_is_compressed(comp), .i_push(push), .i_pop(pop),
        .o_pc(pc_c), .o_misaligned(mis_c), .o_ras_empty(emp_c), .o_ras_full(full_c)
    );

    pc_gen #(.ADDR_W(32), .RESET_ADDR(RST), .C_EXT(1'b0), .RAS_DEPTH(DEPTH)) dut_n (
        .i_Clk(clk), .i_reset(reset),
        .i_trap_flag(trap_flag), .i_trap_addr(trap_addr),
        .i_jump_flag(jump_flag), .i_jump_addr(jump_addr),
        .i_hold(hold), .i_is_compressed(comp), .i_push(push), .i_pop(pop),
        .o_pc(pc_n), .o_misaligned(mis_n), .o_ras_empty(emp_n), .o_ras_full(full_n)
    );

    // Model: index 0 = C_EXT=1 instance, 1 = C_EXT=0 instance.
    // The RAS is a plain list, oldest at [0], newest at [cnt-1].
    logic [31:0] m_pc  [2];
    logic        m_mis [2];
    int          m_cnt [2];
    logic [31:0] m_lst [2][DEPTH];
    bit          m_valid = 1'b0;

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            logic [31:0] mask, seq, nxt;
            bit ck;
            ck = (k == 0);
            if (reset) begin
                m_pc[k] = RST; m_cnt[k] = 0; m_mis[k] = 1'b0;
            end else if (trap_flag) begin
                m_pc[k]  = {trap_addr[31:2], 2'b00};
                m_mis[k] = (trap_addr % 4) != 0;
            end else if (jump_flag) begin
                mask     = ck ? 32'hFFFF_FFFE : 32'hFFFF_FFFC;
                m_pc[k]  = jump_addr & mask;
                m_mis[k] = (jump_addr & ~mask) != 0;
            end else if (hold) begin
                m_mis[k] = 1'b0;
            end else begin
                m_mis[k] = 1'b0;
                seq = m_pc[k] + ((ck && comp) ? 32'd2 : 32'd4);
                nxt = seq;
                if (pop && m_cnt[k] > 0) begin
                    nxt = m_lst[k][m_cnt[k]-1];
                    m_cnt[k] = m_cnt[k] - 1;
                end
                if (push) begin
                    if (m_cnt[k] == DEPTH) begin
                        for (int i = 0; i < DEPTH-1; i++) m_lst[k][i] = m_lst[k][i+1];
                        m_lst[k][DEPTH-1] = seq;
                    end else begin
                        m_lst[k][m_cnt[k]] = seq;
                        m_cnt[k] = m_cnt[k] + 1;
                    end
                end
                m_pc[k] = nxt;
            end
        end
        if (reset) m_valid = 1'b1;
    end

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            cmp("model_pc_c",   pc_c,   m_pc[0]);
            cmp("model_mis_c",  {31'd0, mis_c},  {31'd0, m_mis[0]});
            cmp("model_emp_c",  {31'd0, emp_c},  {31'd0, m_cnt[0] == 0});
            cmp("model_full_c", {31'd0, full_c}, {31'd0, m_cnt[0] == DEPTH});
            cmp("model_pc_n",   pc_n,   m_pc[1]);
            cmp("model_mis_n",  {31'd0, mis_n},  {31'd0, m_mis[1]});
            cmp("model_emp_n",  {31'd0, emp_n},  {31'd0, m_cnt[1] == 0});
            cmp("model_full_n", {31'd0, full_n}, {31'd0, m_cnt[1] == DEPTH});
        end
    end

    task automatic idle();
        reset = 0; trap_flag = 0; jump_flag = 0; hold = 0; comp = 0; push = 0; pop = 0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic jump_to(input logic [31:0] a);
        jump_flag = 1; jump_addr = a;
        cyc();
    endtask

    initial begin
        // Reset and free-running fetch
        reset = 1; cyc();
        cmp("rst_pc", pc_c, 32'h8000_0000);
        cmp("rst_empty", {31'd0, emp_c}, 32'd1);
        cmp("rst_mis", {31'd0, mis_c}, 32'd0);
        cyc(); cmp("seq1", pc_c, 32'h8000_0004);
        cyc(); cmp("seq2", pc_c, 32'h8000_0008);
        cyc(); cmp("seq3", pc_n, 32'h8000_000C);

        // Compressed stepping on both instances
        jump_to(32'h100);
        comp = 1; cyc();
        cmp("cstep_c1", pc_c, 32'h102);
        cmp("cstep_n1", pc_n, 32'h104);
        cyc();
        cmp("cstep_c2", pc_c, 32'h106);
        cmp("cstep_n2", pc_n, 32'h108);

        // Misaligned jump beats hold and pop; RAS left alone
        push = 1; cyc();
        jump_flag = 1; jump_addr = 32'h203; hold = 1; pop = 1; cyc();
        cmp("mjump_pc_c", pc_c, 32'h202);
        cmp("mjump_pc_n", pc_n, 32'h200);
        cmp("mjump_mis_c", {31'd0, mis_c}, 32'd1);
        cmp("mjump_mis_n", {31'd0, mis_n}, 32'd1);
        cmp("mjump_ras", {31'd0, emp_c}, 32'd0);
        cyc();
        cmp("mis_pulse", {31'd0, mis_c}, 32'd0);
        cmp("after_jump", pc_c, 32'h206);
        trap_flag = 1; trap_addr = 32'h40; jump_flag = 1; jump_addr = 32'h80; cyc();
        cmp("trap_prio", pc_c, 32'h40);

        // RAS fill, overwrite of the oldest, and drain
        reset = 1; cyc();
        for (int i = 1; i <= 5; i++) begin
            jump_to(32'h10 * i);
            push = 1; cyc();
            if (i == 4) cmp("ras_full4", {31'd0, full_c}, 32'd1);
        end
        pop = 1; cyc(); cmp("pop1", pc_c, 32'h54);
        pop = 1; cyc(); cmp("pop2", pc_c, 32'h44);
        pop = 1; cyc(); cmp("pop3", pc_c, 32'h34);
        pop = 1; cyc(); cmp("pop4", pc_c, 32'h24);
        cmp("ras_drained", {31'd0, emp_c}, 32'd1);
        pop = 1; cyc(); cmp("pop5_seq", pc_c, 32'h28);

        // Push and pop together
        reset = 1; cyc();
        jump_to(32'h4FC);
        push = 1; cyc();
        jump_to(32'h600);
        push = 1; pop = 1; cyc();
        cmp("pushpop_pc", pc_c, 32'h500);
        cmp("pushpop_cnt", {31'd0, emp_c}, 32'd0);
        pop = 1; cyc();
        cmp("pushpop_top", pc_c, 32'h604);
        cmp("pushpop_emp", {31'd0, emp_c}, 32'd1);

        // Address wrap and reset priority
        jump_to(32'hFFFF_FFFC);
        cyc(); cmp("wrap", pc_c, 32'h0);
        push = 1; cyc();
        reset = 1; jump_flag = 1; jump_addr = 32'h1234; pop = 1; cyc();
        cmp("rst_prio_pc", pc_c, RST);
        cmp("rst_prio_emp", {31'd0, emp_c}, 32'd1);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            reset     = ($urandom_range(0, 99) == 0);
            trap_flag = ($urandom_range(0, 15) == 0);
            jump_flag = ($urandom_range(0, 9) == 0);
            hold      = ($urandom_range(0, 5) == 0);
            comp      = $urandom_range(0, 1);
            push      = ($urandom_range(0, 2) == 0);
            pop       = ($urandom_range(0, 2) == 0);
            trap_addr = $urandom;
            jump_addr = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
            @(posedge clk);
            #1;
        end
        idle();
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
